// File: rtl/qerv_rf_pkg.sv
// qerv register-file RAM: shared derived widths and clear-sequencer state encoding.
// Optional feature macro used by this block: QERV_RF_PARITY_EN.
package qerv_rf_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_CSR_REGS = 4;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } clr_state_e;

    // Register address width: 32 GPRs plus the CSR block.
    function automatic int rf_raw(input int csr_regs);
        return $clog2(32 + csr_regs);
    endfunction

    function automatic int rf_l2w(input int width);
        return $clog2(width);
    endfunction

    // Each register is 32 bits, split over 32/width RAM words.
    function automatic int rf_aw(input int width, input int csr_regs);
        return 5 + rf_raw(csr_regs) - rf_l2w(width);
    endfunction

    function automatic int rf_depth(input int width, input int csr_regs);
        return 32 * (32 + csr_regs) / width;
    endfunction

endpackage

// File: rtl/qerv_rf_clr_seq.sv
// Post-reset clear sequencer: walks every RAM word once, writing zero, then
// parks in RUN until the next reset.
//
//   state | meaning
//   CLEAR | sweep in progress, word clr_cnt written with 0 this cycle
//   RUN   | sweep done, RAM owned by the external interface
module qerv_rf_clr_seq
    import qerv_rf_pkg::*;
#(
    parameter int aw    = 8,
    parameter int depth = 144
) (
    input  logic          i_clk,
    input  logic          i_rst,
    output logic          o_clr_we,
    output logic [aw-1:0] o_clr_addr,
    output logic          o_busy
);

    localparam logic [aw-1:0] LAST_ADDR = aw'(depth - 1);

    clr_state_e    state_q, state_d;
    logic [aw-1:0] clr_cnt_q, clr_cnt_d;

    // State and sweep counter registers; reset always restarts from word 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Next-state logic; the counter stops at the last word, so it never wraps.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        o_clr_we  = 1'b0;
        case (state_q)
            CLEAR: begin
                o_clr_we = ~i_rst;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = RUN;
                end else begin
                    clr_cnt_d = clr_cnt_q + aw'(1);
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    assign o_clr_addr = clr_cnt_q;
    assign o_busy     = (state_q == CLEAR);

endmodule

// File: rtl/qerv_rf_ram_clr.sv
// qerv register-file RAM with a zeroing sweep after every reset.
// Synchronous single-write/single-read RAM, read latency 1, read-old on a
// same-address collision. Out-of-range writes are dropped, reads return 0.
// Optional feature macro: QERV_RF_PARITY_EN adds a stored even-parity bit
// per word, an o_perr read flag and an i_perr_inj parity corruption hook.
module qerv_rf_ram_clr
    import qerv_rf_pkg::*;
#(
    parameter int width    = DEF_WIDTH,
    parameter int csr_regs = DEF_CSR_REGS,
    localparam int raw     = rf_raw(csr_regs),
    localparam int l2w     = rf_l2w(width),
    localparam int aw      = rf_aw(width, csr_regs),
    localparam int depth   = rf_depth(width, csr_regs)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [aw-1:0]    i_waddr,
    input  logic [width-1:0] i_wdata,
    input  logic             i_wen,
    input  logic [aw-1:0]    i_raddr,
    input  logic             i_ren,
    output logic [width-1:0] o_rdata,
    output logic             o_busy
`ifdef QERV_RF_PARITY_EN
    ,
    input  logic             i_perr_inj,
    output logic             o_perr
`endif
);

`ifdef QERV_RF_PARITY_EN
    localparam int DW = width + 1;
`else
    localparam int DW = width;
`endif

    localparam logic [aw:0] DEPTH_V = (aw + 1)'(depth);

    logic             clr_we;
    logic [aw-1:0]    clr_addr;
    logic             busy;

    logic             ram_we;
    logic [aw-1:0]    ram_waddr;
    logic [width-1:0] ram_wdata;
    logic [DW-1:0]    ram_wword;
    logic [DW-1:0]    ram_rword;
    logic             w_in_range;
    logic             r_in_range;

    logic [width-1:0] rdata_q, rdata_d;

    logic [DW-1:0]    mem [depth];

    qerv_rf_clr_seq #(
        .aw    (aw),
        .depth (depth)
    ) u_clr_seq (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .o_clr_we   (clr_we),
        .o_clr_addr (clr_addr),
        .o_busy     (busy)
    );

    assign w_in_range = ({1'b0, i_waddr} < DEPTH_V);
    assign r_in_range = ({1'b0, i_raddr} < DEPTH_V);

    // Write-port mux: the sequencer owns the RAM while busy; nothing is
    // written while reset is asserted.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = i_waddr;
        ram_wdata = i_wdata;
        if (i_rst) begin
            ram_we = 1'b0;
        end else if (busy) begin
            ram_we    = clr_we;
            ram_waddr = clr_addr;
            ram_wdata = '0;
        end else begin
            ram_we = i_wen & w_in_range;
        end
    end

`ifdef QERV_RF_PARITY_EN
    logic perr_q, perr_d;
    logic perr_inj;

    // Injection is ignored during the sweep so cleared words carry parity 0.
    assign perr_inj  = i_perr_inj & ~busy;
    assign ram_wword = {(^ram_wdata) ^ perr_inj, ram_wdata};
`else
    assign ram_wword = ram_wdata;
`endif

    // RAM array write; contents are only ever cleared by the sweep.
    always_ff @(posedge i_clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wword;
        end
    end

    assign ram_rword = r_in_range ? mem[i_raddr] : '0;

    // Read data next value: forced to 0 while busy, held when not reading.
    always_comb begin
        rdata_d = rdata_q;
        if (busy) begin
            rdata_d = '0;
        end else if (i_ren) begin
            rdata_d = ram_rword[width-1:0];
        end
    end

    // Registered read data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign o_rdata = rdata_q;
    assign o_busy  = busy;

`ifdef QERV_RF_PARITY_EN
    // Parity flag next value: one-cycle pulse alongside the read data. The
    // stored word is all-zero for out-of-range reads, so its XOR is 0.
    always_comb begin
        perr_d = 1'b0;
        if (!busy && i_ren) begin
            perr_d = ^ram_rword;
        end
    end

    // Registered parity flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign o_perr = perr_q;
`endif

endmodule

// File: tb/tb_qerv_rf_ram_clr.sv
// Self-checking bench for qerv_rf_ram_clr at default parameters (depth 144).
// Parity checks are compiled in when QERV_RF_PARITY_EN is defined.
module tb_qerv_rf_ram_clr;

    localparam int DEPTH = 144;

    logic       clk;
    logic       rst;
    logic [7:0] waddr;
    logic [7:0] wdata;
    logic       wen;
    logic [7:0] raddr;
    logic       ren;
    logic [7:0] rdata;
    logic       busy;
`ifdef QERV_RF_PARITY_EN
    logic       perr_inj;
    logic       perr;
`endif

    int n_cmp = 0;
    int n_err = 0;

    qerv_rf_ram_clr dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_waddr (waddr),
        .i_wdata (wdata),
        .i_wen   (wen),
        .i_raddr (raddr),
        .i_ren   (ren),
        .o_rdata (rdata),
        .o_busy  (busy)
`ifdef QERV_RF_PARITY_EN
        ,
        .i_perr_inj (perr_inj),
        .o_perr     (perr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wen;
        logic [7:0] waddr;
        logic [7:0] wdata;
        logic       ren;
        logic [7:0] raddr;
        logic [7:0] exp;
    } vec_t;

    vec_t vt[20];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        wen = 1'b1; waddr = a; wdata = d;
        tick();
        wen = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        ren = 1'b1; raddr = a;
        tick();
        ren = 1'b0;
        d = rdata;
    endtask

    // Counts cycles with busy high, starting in the cycle after reset release.
    task automatic count_busy(output int n, output int rd_nz);
        n = 0;
        rd_nz = 0;
        while (busy && n < 1000) begin
            if (rdata !== 8'h00) rd_nz++;
            n++;
            tick();
        end
    endtask

    initial begin
        int         nb;
        int         nz;
        logic [7:0] d;

        vt[0]  = '{1'b1, 8'd10,  8'hA5, 1'b0, 8'd0,   8'h00};
        vt[1]  = '{1'b0, 8'd0,   8'h00, 1'b1, 8'd10,  8'hA5};
        vt[2]  = '{1'b0, 8'd0,   8'h00, 1'b0, 8'd0,   8'hA5};
        vt[3]  = '{1'b0, 8'd0,   8'h00, 1'b1, 8'd0,   8'h00};
        vt[4]  = '{1'b0, 8'd0,   8'h00, 1'b1, 8'd10,  8'hA5};
        vt[5]  = '{1'b0, 8'd0,   8'h00, 1'b1, 8'd77,  8'h00};
        vt[6]  = '{1'b0, 8'd0,   8'h00, 1'b1, 8'd10,  8'hA5};
        vt[7]  = '{1'b0, 8'd0,   8'h00, 1'b1, 8'd143, 8'h00};
        vt[8]  = '{1'b1, 8'd20,  8'h11, 1'b0, 8'd0,   8'h00};
        vt[9]  = '{1'b1, 8'd20,  8'h3C, 1'b1, 8'd20,  8'h11};
        vt[10] = '{1'b0, 8'd0,   8'h00, 1'b1, 8'd20,  8'h3C};
        vt[11] = '{1'b1, 8'd200, 8'h12, 1'b0, 8'd0,   8'h3C};
        vt[12] = '{1'b0, 8'd0,   8'h00, 1'b1, 8'd200, 8'h00};
        vt[13] = '{1'b0, 8'd0,   8'h00, 1'b1, 8'd10,  8'hA5};
        vt[14] = '{1'b0, 8'd0,   8'h00, 1'b1, 8'd56,  8'h00};
        vt[15] = '{1'b1, 8'd143, 8'h5A, 1'b0, 8'd0,   8'h00};
        vt[16] = '{1'b0, 8'd0,   8'h00, 1'b1, 8'd143, 8'h5A};
        vt[17] = '{1'b1, 8'd144, 8'h77, 1'b0, 8'd0,   8'h5A};
        vt[18] = '{1'b0, 8'd0,   8'h00, 1'b1, 8'd144, 8'h00};
        vt[19] = '{1'b0, 8'd0,   8'h00, 1'b1, 8'd0,   8'h00};

        rst = 1'b1; wen = 1'b0; ren = 1'b0;
        waddr = '0; wdata = '0; raddr = '0;
`ifdef QERV_RF_PARITY_EN
        perr_inj = 1'b0;
`endif

        // Two-cycle reset, then the first sweep.
        tick();
        chk("reset_busy", busy, 1'b1);
        chk("reset_rdata", rdata, 8'h00);
        tick();
        rst = 1'b0;
        count_busy(nb, nz);
        chk("sweep1_busy_cycles", nb, DEPTH);
        chk("sweep1_rdata_nonzero", nz, 0);

        // Directed vectors in RUN.
        for (int i = 0; i < 20; i++) begin
            wen   = vt[i].wen;
            waddr = vt[i].waddr;
            wdata = vt[i].wdata;
            ren   = vt[i].ren;
            raddr = vt[i].raddr;
            tick();
            chk($sformatf("vec%0d_rdata", i), rdata, vt[i].exp);
            chk($sformatf("vec%0d_busy", i), busy, 1'b0);
        end
        wen = 1'b0; ren = 1'b0;

        // Reset mid-sweep restarts from word 0.
        wr(8'd5, 8'hFF);
        rd(8'd5, d);
        chk("word5_pre_reset", d, 8'hFF);
        rst = 1'b1;
        tick();
        chk("reset2_busy", busy, 1'b1);
        chk("reset2_rdata", rdata, 8'h00);
        rst = 1'b0;
        repeat (60) tick();
        chk("sweep2_mid_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        // External traffic during the sweep must be ignored.
        wen = 1'b1; waddr = 8'd3; wdata = 8'hEE;
        ren = 1'b1; raddr = 8'd5;
        count_busy(nb, nz);
        wen = 1'b0; ren = 1'b0;
        chk("sweep3_busy_cycles", nb, DEPTH);
        chk("sweep3_rdata_nonzero", nz, 0);
        rd(8'd5, d);
        chk("word5_after_sweep", d, 8'h00);
        rd(8'd3, d);
        chk("word3_ext_write_ignored", d, 8'h00);
        rd(8'd10, d);
        chk("word10_after_sweep", d, 8'h00);
        rd(8'd143, d);
        chk("word143_after_sweep", d, 8'h00);

`ifdef QERV_RF_PARITY_EN
        perr_inj = 1'b1;
        wr(8'd3, 8'h07);
        perr_inj = 1'b0;
        rd(8'd3, d);
        chk("par_inj_rdata", d, 8'h07);
        chk("par_inj_perr", perr, 1'b1);
        tick();
        chk("par_perr_pulse_end", perr, 1'b0);
        wr(8'd4, 8'h07);
        rd(8'd4, d);
        chk("par_clean_rdata", d, 8'h07);
        chk("par_clean_perr", perr, 1'b0);
        rd(8'd3, d);
        chk("par_inj_perr_again", perr, 1'b1);
        rd(8'd200, d);
        chk("par_oob_perr", perr, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/qerv_rf_ram_clr.md
Name: qerv_rf_ram_clr

Overview:
- Register-file SRAM stage directly downstream of the qerv RF RAM interface. It consumes waddr/wdata/wen/raddr/ren from that interface and returns rdata.
- Holds the GPR+CSR storage as a synchronous single-write/single-read RAM.
- After every reset, a clear sequencer writes zero to every word. o_busy is asserted throughout the sweep so the top level can hold the core in reset until the sweep is done.

Parameters:
- width, 8: RAM data width in bits. Must match the interface stage.
- csr_regs, 4: number of CSR registers stored after the 32 GPRs.
- raw, $clog2(32+csr_regs): register address width. Derived; do not override.
- l2w, $clog2(width): log2 of width. Derived.
- aw, 5+raw-l2w: RAM address width. Derived; 8 at defaults.
- depth, 32*(32+csr_regs)/width: number of implemented words. Derived; 144 at defaults.

Ports:
- i_clk  in  1  clock, single clock domain, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_waddr  in  aw  write word address.
- i_wdata  in  width  write data.
- i_wen  in  1  write enable.
- i_raddr  in  aw  read word address.
- i_ren  in  1  read enable.
- o_rdata  out  width  read data, registered.
- o_busy  out  1  clear sweep in progress; external accesses are not serviced.

Behaviour:
- One clock, i_clk. i_rst is synchronous and active-high.
- Reset, with i_rst high at a clock edge:
  - o_busy <= 1, o_rdata <= 0, clear counter <= 0, FSM <= CLEAR.
  - No RAM write occurs in a cycle where i_rst is high.
- FSM states:
  - CLEAR: every cycle write 0 to word clr_cnt, then clr_cnt += 1. In the cycle clr_cnt == depth-1, that word is written and the FSM moves to RUN.
  - RUN: normal operation. Leaves RUN only on i_rst.
- Clear timing: the first cycle with i_rst low writes word 0. o_busy is 1 during all depth sweep cycles and reads 0 in the cycle after the last clear write. Total busy time after reset release is exactly depth cycles (144 at defaults).
- During CLEAR:
  - i_wen, i_ren, i_waddr and i_raddr are ignored; no external write reaches the RAM.
  - o_rdata is held at 0.
- i_rst asserted mid-CLEAR restarts the sweep from word 0. There is no partial-state carryover.
- Write (RUN): if i_wen=1 and i_waddr < depth, mem[i_waddr] <= i_wdata at the clock edge.
- Read (RUN), latency 1:
  - If i_ren=1 at edge N, o_rdata shows mem[i_raddr] from edge N onward, i.e. valid in cycle N+1.
  - If i_ren=0, o_rdata holds its previous value.
- Read-during-write to the same address in the same cycle is read-old: o_rdata returns the value before the write.
- Out of range (address >= depth):
  - Writes are dropped.
  - Reads return 0 into o_rdata.
- Word contents are never reset except by the sweep. The RAM array itself has no reset.
- clr_cnt width is aw. It never wraps, because the FSM leaves CLEAR at depth-1.

Optional Feature:
- Macro QERV_RF_PARITY_EN.
- When defined:
  - Each word stores width+1 bits; the extra bit is the even parity (XOR) of the data.
  - The sweep writes data 0 with parity 0.
  - Extra output o_perr (1 bit) pulses high for one cycle, aligned with o_rdata, when a RUN read returns a word whose stored parity mismatches.
  - Extra input i_perr_inj (1 bit): when high during a write, the stored parity bit is inverted. This is a test hook.
  - Out-of-range reads give o_perr=0. o_perr resets to 0.
- When not defined: no extra storage bit and no o_perr or i_perr_inj ports.

Decomposition:
- Package qerv_rf_pkg holds the derived-width functions or constants raw, l2w, aw, depth, and the FSM state encoding: CLEAR=1'b0, RUN=1'b1.
- One sub-module, qerv_rf_clr_seq: the FSM plus clr_cnt. Outputs clr_we, clr_addr and busy.
- The top level muxes the RAM write port between the sequencer and i_waddr/i_wdata on busy, and contains the RAM array.

Test Plan:
- Pulse i_rst for 2 cycles then release. Expect o_busy=1 for exactly 144 cycles, then 0. Reading words 0, 77 and 143 then gives 0x00.
- After busy drops, write 0xA5 to word 10. Read word 10 next cycle with ren=1. Expect o_rdata=0xA5 one cycle after the read edge; with ren=0 afterwards, o_rdata stays 0xA5.
- Same cycle: write 0x3C to word 20, which holds 0x11, and read word 20. Expect o_rdata=0x11; a read in the next cycle gives 0x3C.
- Write 0xFF to word 5, then assert i_rst for 1 cycle at sweep count 60 of a second reset. Expect the sweep to restart: busy lasts 144 cycles from the latest release, and word 5 reads 0x00.
- Write 0x12 to word 200 (out of range), then read word 200. Expect o_rdata=0x00, and word 200-144=56 unchanged.
- With QERV_RF_PARITY_EN defined: write 0x07 to word 3 with i_perr_inj=1, then read it. Expect o_rdata=0x07 and o_perr=1 for one cycle. A clean write and read of 0x07 gives o_perr=0.
